// File: rtl/p_stack_pkg.sv
// Shared SM-core constants. The predicate stack reads its lane count from here.
package p_stack_pkg;

    localparam int N_CORES    = 4;
    localparam int CLK_PERIOD = 10;

endpackage

// File: rtl/p_stack.sv
// Predicate (active-lane mask) stack: push on branch entry, complement on the else
// path, pop on reconvergence. The top entry is the lane-enable mask for the cores.
module p_stack #(
    parameter int N_CORES = p_stack_pkg::N_CORES,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CORES-1:0] d,
    output logic [N_CORES-1:0] q,
    input  logic               push,
    input  logic               pop,
    input  logic               comp,
    output logic               all_true,
    output logic               all_false
);

    localparam int SPW = $clog2(DEPTH + 1);

    typedef logic [SPW-1:0] sp_t;
    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_COMP} op_e;

    localparam sp_t SP_MAX = sp_t'(DEPTH);
    localparam sp_t SP_ONE = sp_t'(1);

    // The all-ones base entry at sp = 0 is implied, not stored.
    logic [N_CORES-1:0] mem [1:DEPTH];
    sp_t                sp;
    logic [N_CORES-1:0] parent;
    op_e                op;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        q      = '1;
        parent = '1;
        if (sp != '0) q = mem[sp];
        if (sp > SP_ONE) parent = mem[sp - SP_ONE];
    end

    assign all_true  = &q;
    assign all_false = ~|q;

    // Priority picks the command first; a blocked winner does not fall through to a lower one.
    always_comb begin
        op = OP_NONE;
        if (push) begin
            if (sp < SP_MAX) op = OP_PUSH;
        end else if (pop) begin
            if (sp != '0) op = OP_POP;
        end else if (comp) begin
            if (sp != '0) op = OP_COMP;
        end
    end

    // NOTE: state uses non-blocking assignments; the mask array is reset too so q is defined after any pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= '0;
            for (int i = 1; i <= DEPTH; i++) mem[i] <= '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    mem[sp + SP_ONE] <= d & q;
                    sp               <= sp + SP_ONE;
                end
                OP_POP:  sp      <= sp - SP_ONE;
                OP_COMP: mem[sp] <= ~q & parent;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_p_stack.sv
// Self-checking bench for p_stack: expected masks are queued as commands are issued
// and compared by a monitor on the following falling edge.
module tb_p_stack;

    localparam int N     = p_stack_pkg::N_CORES;
    localparam int DEPTH = 8;
    localparam int HALF  = p_stack_pkg::CLK_PERIOD / 2;

    typedef struct {
        logic [N-1:0] q;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] d = '0;
    logic [N-1:0] q;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic         comp = 1'b0;
    logic         all_true;
    logic         all_false;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    p_stack #(.N_CORES(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .d(d), .q(q), .push(push), .pop(pop),
        .comp(comp), .all_true(all_true), .all_false(all_false)
    );

    always #HALF clk = ~clk;

    // Scoreboard monitor: one expectation per command, checked the falling edge after it was clocked.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic exp_at, exp_af;
            e = sb.pop_front();
            exp_at = &e.q;
            exp_af = ~|e.q;
            checks++;
            if ({q, all_true, all_false} !== {e.q, exp_at, exp_af}) begin
                errors++;
                $display("FAIL %s: q=%b all_true=%b all_false=%b, expected q=%b all_true=%b all_false=%b",
                         e.name, q, all_true, all_false, e.q, exp_at, exp_af);
            end
        end
    end

    initial begin
        #(200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic p_push, input logic p_pop, input logic p_comp,
                        input logic [N-1:0] p_d, input logic [N-1:0] exp_q, input string name);
        exp_t e;
        @(negedge clk);
        push = p_push;
        pop  = p_pop;
        comp = p_comp;
        d    = p_d;
        @(posedge clk);
        e.q = exp_q;
        e.name = name;
        sb.push_back(e);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        comp = 1'b0;
        d    = 'x;
    endtask

    task automatic drain();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({q, all_true, all_false} !== {4'b1111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: q=%b at=%b af=%b, expected 1111 1 0", q, all_true, all_false);
        end
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 4'b0000, 4'b1111, "reset_idle");
        step(0, 1, 0, 4'b0000, 4'b1111, "pop_empty");
        step(0, 0, 1, 4'b0000, 4'b1111, "comp_empty");
        drain();
    endtask

    task automatic test_nest_comp_unwind();
        step(1, 0, 0, 4'b1010, 4'b1010, "push_1010");
        step(1, 0, 0, 4'b0011, 4'b0010, "push_0011");
        step(1, 0, 0, 4'b0111, 4'b0010, "push_0111");
        step(1, 0, 0, 4'b0000, 4'b0000, "push_0000");
        step(0, 0, 1, 4'b0000, 4'b0010, "comp_1");
        step(0, 0, 1, 4'b0000, 4'b0000, "comp_2");
        step(0, 1, 0, 4'b0000, 4'b0010, "unwind_1");
        step(0, 1, 0, 4'b0000, 4'b0010, "unwind_2");
        step(0, 1, 0, 4'b0000, 4'b1010, "unwind_3");
        step(0, 1, 0, 4'b0000, 4'b1111, "unwind_4");
        step(0, 1, 0, 4'b0000, 4'b1111, "unwind_5_empty");
        drain();
    endtask

    task automatic test_comp_base_parent();
        // With sp=1 the parent is the base, so comp yields the plain complement.
        step(1, 0, 0, 4'b0110, 4'b0110, "push_0110");
        step(0, 0, 1, 4'b0000, 4'b1001, "comp_sp1");
        step(0, 1, 0, 4'b0000, 4'b1111, "pop_sp1");
        drain();
    endtask

    task automatic test_full();
        step(1, 0, 0, 4'b1110, 4'b1110, "fill_first");
        for (int i = 1; i < DEPTH; i++) step(1, 0, 0, 4'b1111, 4'b1110, "fill");
        step(1, 0, 0, 4'b0000, 4'b1110, "push_full_ignored");
        for (int i = 1; i < DEPTH; i++) step(0, 1, 0, 4'b0000, 4'b1110, "drain_pop");
        step(0, 1, 0, 4'b0000, 4'b1111, "drain_to_base");
        step(0, 1, 0, 4'b0000, 4'b1111, "drain_past_base");
        drain();
    endtask

    task automatic test_priority();
        step(1, 1, 0, 4'b1001, 4'b1001, "push_beats_pop");
        step(0, 1, 1, 4'b0000, 4'b1111, "pop_beats_comp");
        step(1, 0, 0, 4'b1100, 4'b1100, "push_1100");
        step(1, 0, 1, 4'b0101, 4'b0100, "push_beats_comp");
        step(0, 1, 0, 4'b0000, 4'b1100, "pop_after_prio");
        step(0, 1, 0, 4'b0000, 4'b1111, "pop_to_base");
        drain();
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 4'b1100, 4'b1100, "mid_push_1");
        step(1, 0, 0, 4'b0100, 4'b0100, "mid_push_2");
        step(1, 0, 0, 4'b1111, 4'b0100, "mid_push_3");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({q, all_true, all_false} !== {4'b1111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: q=%b at=%b af=%b, expected 1111 1 0", q, all_true, all_false);
        end
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 0, 4'b0000, 4'b1111, "pop_after_reset_1");
        step(0, 1, 0, 4'b0000, 4'b1111, "pop_after_reset_2");
        drain();
    endtask

    initial begin
        test_reset();
        test_nest_comp_unwind();
        test_comp_base_parent();
        test_full();
        test_priority();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
